mesh_out_deskew: RTL and testbench



---
 rtl/mesh_pkg.sv | 23 ++
 rtl/mesh_row_fifo.sv | 61 ++++++
 rtl/mesh_out_deskew.sv | 122 ++++++++++++
 tb/tb_mesh_out_deskew.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// rtl/mesh_pkg.sv - shared widths, row-element type and saturation helper for the mesh output path
package mesh_pkg;

    localparam int C_W_DEF = 19;
    localparam int A_W_DEF = 8;

    typedef logic signed [C_W_DEF-1:0] elem_t;

    // Clamp a signed value into the signed range of a w-bit word (w <= 32).
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/mesh_row_fifo.sv
// rtl/mesh_row_fifo.sv - registered synchronous row FIFO with push/pop/count and drop indication
module mesh_row_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clock,
    input  logic          RST,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o,
    output logic          drop_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_ok;
    logic          push_ok;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i & (count_q != '0);
    assign push_ok = push_i & ((count_q != CW'(DEPTH)) | pop_ok);
    assign drop_o  = push_i & ~push_ok;

    always_ff @(posedge clock) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/mesh_out_deskew.sv
// rtl/mesh_out_deskew.sv - deskews PE-mesh column outputs into rows and buffers them; MESH_OUT_SAT_EN adds saturation
module mesh_out_deskew
    import mesh_pkg::*;
#(
    parameter int COLS  = 4,
    parameter int C_W   = C_W_DEF,
    parameter int A_W   = A_W_DEF,
    parameter int DEPTH = 8,
`ifdef MESH_OUT_SAT_EN
    localparam int OUT_W = A_W,
`else
    localparam int OUT_W = C_W,
`endif
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  RST,
    input  logic [COLS*C_W-1:0]   in_c,
    input  logic [COLS-1:0]       in_valid,
    output logic [COLS*OUT_W-1:0] out_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  skew_err,
    input  logic                  clr_err
);

    logic [COLS-1:0]       av;
    logic [COLS*C_W-1:0]   ad;
    logic [COLS*OUT_W-1:0] wrow;
    logic                  push_cand;
    logic                  skew_evt;
    logic                  drop;
    logic                  overflow_q;
    logic                  skew_err_q;

    // Column j arrives j cycles after column 0, so it is delayed COLS-1-j cycles to line up.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int D = COLS - 1 - j;
        if (D == 0) begin : g_pass
            assign av[j]              = in_valid[j];
            assign ad[j*C_W +: C_W]   = in_c[j*C_W +: C_W];
        end else begin : g_dly
            logic [D-1:0]   vld_q;
            logic [C_W-1:0] dat_q [D];

            always_ff @(posedge clock) begin
                if (!RST) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= in_valid[j];
                    for (int k = 1; k < D; k++) begin
                        vld_q[k] <= vld_q[k-1];
                    end
                end
            end

            always_ff @(posedge clock) begin
                dat_q[0] <= in_c[j*C_W +: C_W];
                for (int k = 1; k < D; k++) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end

            assign av[j]            = vld_q[D-1];
            assign ad[j*C_W +: C_W] = dat_q[D-1];
        end
    end

    always_comb begin
        wrow = '0;
`ifdef MESH_OUT_SAT_EN
        for (int j = 0; j < COLS; j++) begin
            wrow[j*OUT_W +: OUT_W] = OUT_W'(sat_s(32'($signed(ad[j*C_W +: C_W])), A_W));
        end
`else
        wrow = ad;
`endif
    end

    assign push_cand = &av;
    assign skew_evt  = (|av) & ~(&av);

    mesh_row_fifo #(
        .W     (COLS * OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .RST     (RST),
        .push_i  (push_cand),
        .wdata_i (wrow),
        .pop_i   (out_ready),
        .rdata_o (out_row),
        .valid_o (out_valid),
        .count_o (count),
        .drop_o  (drop)
    );

    // A flag set in the same cycle as clr_err wins over the clear.
    always_ff @(posedge clock) begin
        if (!RST) begin
            overflow_q <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_err) begin
                overflow_q <= 1'b0;
            end
            if (skew_evt) begin
                skew_err_q <= 1'b1;
            end else if (clr_err) begin
                skew_err_q <= 1'b0;
            end
        end
    end

    assign overflow = overflow_q;
    assign skew_err = skew_err_q;

endmodule

// File: tb/tb_mesh_out_deskew.sv
// tb/tb_mesh_out_deskew.sv - directed self-checking bench for mesh_out_deskew
module tb_mesh_out_deskew;

    localparam int COLS  = 4;
    localparam int C_W   = 19;
    localparam int A_W   = 8;
    localparam int DEPTH = 8;
`ifdef MESH_OUT_SAT_EN
    localparam int OUT_W = A_W;
`else
    localparam int OUT_W = C_W;
`endif

    logic                  clock = 1'b0;
    logic                  RST = 1'b0;
    logic [COLS*C_W-1:0]   in_c = '0;
    logic [COLS-1:0]       in_valid = '0;
    logic [COLS*OUT_W-1:0] out_row;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [3:0]            count;
    logic                  overflow;
    logic                  skew_err;
    logic                  clr_err = 1'b0;

    int checks = 0;
    int errors = 0;
    int rows [16][COLS];
    logic [COLS-1:0] masks [16];

    mesh_out_deskew #(
        .COLS  (COLS),
        .C_W   (C_W),
        .A_W   (A_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .RST       (RST),
        .in_c      (in_c),
        .in_valid  (in_valid),
        .out_row   (out_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .skew_err  (skew_err),
        .clr_err   (clr_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [COLS*OUT_W-1:0] exp_row(input int r);
        logic [COLS*OUT_W-1:0] res;
        res = '0;
        for (int j = 0; j < COLS; j++) begin
            res[j*OUT_W +: OUT_W] = OUT_W'(rows[r][j]);
        end
        return res;
    endfunction

    // Drive n rows from rows[base..] with the mesh's diagonal skew; out_ready/clr_err pulse on the given cycles.
    task automatic drive_rows(input int n, input int base, input int rdy_cyc, input int clr_cyc);
        for (int c = 0; c <= n + COLS - 2; c++) begin
            in_valid = '0;
            in_c     = '0;
            for (int j = 0; j < COLS; j++) begin
                int r;
                r = c - j;
                if (r >= 0 && r < n && masks[base + r][j]) begin
                    in_valid[j]          = 1'b1;
                    in_c[j*C_W +: C_W]   = C_W'(rows[base + r][j]);
                end
            end
            out_ready = (c == rdy_cyc);
            clr_err   = (c == clr_cyc);
            step();
        end
        in_valid  = '0;
        in_c      = '0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            masks[r] = '1;
            for (int j = 0; j < COLS; j++) begin
                rows[r][j] = r * 4 + j + 1;
            end
        end
        rows[10][0] = 300;
        rows[10][1] = -300;
        rows[10][2] = 127;
        rows[10][3] = -128;
        rows[13][0] = 1;
        rows[13][1] = 2;
        rows[13][2] = 3;
        rows[13][3] = 4;
        masks[9] = 4'b1011;

        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_skew_err", skew_err, 0);
        RST = 1'b1;
        step();

        // Single skewed row 1,2,3,4: out_valid rises only after the last column's cycle.
        for (int c = 0; c < COLS; c++) begin
            in_valid = '0;
            in_c     = '0;
            in_valid[c]        = 1'b1;
            in_c[c*C_W +: C_W] = C_W'(c + 1);
            step();
            check("single_latency_valid", out_valid, (c == COLS - 1));
        end
        in_valid = '0;
        in_c     = '0;
`ifdef MESH_OUT_SAT_EN
        check("single_row", out_row, {8'd4, 8'd3, 8'd2, 8'd1});
`else
        check("single_row", out_row, {19'd4, 19'd3, 19'd2, 19'd1});
`endif
        check("single_count", count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_pop_count", count, 0);
        check("single_pop_valid", out_valid, 0);

        // Fill to DEPTH, then a ninth row is dropped.
        drive_rows(8, 0, -1, -1);
        check("fill_count", count, 8);
        check("fill_overflow", overflow, 0);
        drive_rows(1, 8, -1, -1);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 8);
        check("ovf_head", out_row, exp_row(0));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_order", out_row, exp_row(i));
            step();
        end
        out_ready = 1'b0;
        check("drain_count", count, 0);
        check("drain_valid", out_valid, 0);
        pulse_clr();
        check("ovf_clr", overflow, 0);

        // Full FIFO with a pop coinciding with the ninth aligned row.
        drive_rows(8, 0, -1, -1);
        drive_rows(1, 8, COLS - 1, -1);
        check("fullpop_count", count, 8);
        check("fullpop_overflow", overflow, 0);
        check("fullpop_head", out_row, exp_row(1));
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("fullpop_drain", out_row, exp_row(i));
            step();
        end
        out_ready = 1'b0;
        check("fullpop_empty", count, 0);

        // Missing column 2 valid.
        drive_rows(1, 9, -1, -1);
        check("skew_set", skew_err, 1);
        check("skew_no_push", count, 0);
        pulse_clr();
        check("skew_clr", skew_err, 0);
        drive_rows(1, 9, -1, COLS - 1);
        check("skew_set_wins", skew_err, 1);
        pulse_clr();
        check("skew_clr2", skew_err, 0);

        // Saturation row 300,-300,127,-128.
        drive_rows(1, 10, -1, -1);
`ifdef MESH_OUT_SAT_EN
        check("sat_row", out_row, {8'h80, 8'h7f, 8'h80, 8'h7f});
`else
        check("sat_row", out_row, {-19'sd128, 19'sd127, -19'sd300, 19'sd300});
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("sat_pop", count, 0);

        // Reset mid-row with a full FIFO and both flags set.
        drive_rows(1, 9, -1, -1);
        drive_rows(8, 0, -1, -1);
        drive_rows(1, 8, -1, -1);
        check("pre_rst_ovf", overflow, 1);
        check("pre_rst_skew", skew_err, 1);
        in_valid = 4'b0001;
        in_c     = '0;
        in_c[0*C_W +: C_W] = C_W'(77);
        step();
        in_valid = 4'b0010;
        in_c     = '0;
        in_c[1*C_W +: C_W] = C_W'(78);
        step();
        in_valid = '0;
        in_c     = '0;
        RST = 1'b0;
        step();
        RST = 1'b1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_skew", skew_err, 0);
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check("partial_gone_valid", out_valid, 0);
        check("partial_gone_skew", skew_err, 0);
        drive_rows(1, 12, -1, -1);
        check("post_rst_row", out_row, exp_row(12));
        check("post_rst_count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
